// File: rtl/writeback_stage.sv
// Writeback stage: registered scalar/vector register-file write ports plus a 4-entry conv result FIFO.
// Optional retired-instruction counter enabled by defining WB_PERF_CNT_EN.
`ifndef INT32
`define INT32 32
`endif
`ifndef INT8
`define INT8 8
`endif
`ifndef LENGTH
`define LENGTH 8
`endif

module writeback_stage #(
  parameter int VW = `LENGTH*`INT8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        opcode,
  input  logic [4:0]        rD,
  input  logic [1:0]        wb,
  input  logic              ldr,
  input  logic [`INT32-1:0] s_result,
  input  logic [VW-1:0]     v_result,
  input  logic [`INT32-1:0] smem,
  input  logic [VW-1:0]     vmem,
  input  logic [VW-1:0]     conv_result,
  input  logic [4:0]        conv_addr,
  input  logic              conv_write,
  output logic              s_we,
  output logic [4:0]        s_waddr,
  output logic [`INT32-1:0] s_wdata,
  output logic              v_we,
  output logic [4:0]        v_waddr,
  output logic [VW-1:0]     v_wdata,
  output logic              conv_stall,
  output logic              conv_overflow,
  output logic [2:0]        conv_count,
  output logic [31:0]       retire_cnt
);

  logic [4:0]    fifo_addr  [4];
  logic [VW-1:0] fifo_data  [4];
  logic [3:0]    fifo_valid;
  logic [1:0]    head, tail;

  logic          pipe_vw, empty, full, bypass, pop, push, push_ok, drop;
  logic [2:0]    count_next;
  logic          v_we_next;
  logic [4:0]    v_waddr_next;
  logic [VW-1:0] v_wdata_next;

  // Pop precedes push: a full FIFO that pops this cycle still accepts a push.
  always_comb begin
    pipe_vw    = (wb == 2'b10);
    empty      = (conv_count == 3'd0);
    full       = (conv_count == 3'd4);
    bypass     = conv_write && empty && !pipe_vw;
    pop        = !pipe_vw && !empty;
    push       = conv_write && !bypass;
    push_ok    = push && (!full || pop);
    drop       = push && full && !pop;
    count_next = conv_count + {2'b00, push_ok} - {2'b00, pop};
  end

  // Pipeline writes own the vector port; conv data uses it only in idle slots.
  always_comb begin
    v_we_next    = 1'b0;
    v_waddr_next = v_waddr;
    v_wdata_next = v_wdata;
    if (pipe_vw) begin
      v_we_next    = 1'b1;
      v_waddr_next = rD;
      v_wdata_next = ldr ? vmem : v_result;
    end else if (bypass) begin
      v_we_next    = 1'b1;
      v_waddr_next = conv_addr;
      v_wdata_next = conv_result;
    end else if (pop) begin
      v_we_next    = fifo_valid[head];
      v_waddr_next = fifo_addr[head];
      v_wdata_next = fifo_data[head];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_we    <= 1'b0;
      s_waddr <= '0;
      s_wdata <= '0;
      v_we    <= 1'b0;
      v_waddr <= '0;
      v_wdata <= '0;
    end else begin
      s_we    <= (wb == 2'b01);
      s_waddr <= rD;
      s_wdata <= ldr ? smem : s_result;
      v_we    <= v_we_next;
      v_waddr <= v_waddr_next;
      v_wdata <= v_wdata_next;
    end
  end

  // Invalidation first, then the push: a same-cycle conv to rD is younger and stays valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_valid    <= '0;
      head          <= '0;
      tail          <= '0;
      conv_count    <= '0;
      conv_stall    <= 1'b0;
      conv_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pipe_vw && fifo_addr[i] == rD) fifo_valid[i] <= 1'b0;
      end
      if (push_ok) begin
        fifo_valid[tail] <= 1'b1;
        tail             <= tail + 2'd1;
      end
      if (pop) head <= head + 2'd1;
      conv_count    <= count_next;
      conv_stall    <= (count_next >= 3'd3);
      conv_overflow <= conv_overflow | drop;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_addr[tail] <= conv_addr;
      fifo_data[tail] <= conv_result;
    end
  end

`ifdef WB_PERF_CNT_EN
  logic [31:0] retire_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) retire_q <= '0;
    else if ((wb == 2'b01 || wb == 2'b10) && opcode != 5'd0) retire_q <= retire_q + 32'd1;
  end

  assign retire_cnt = retire_q;
`else
  assign retire_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed stimulus pushes expected register-file
// writes into queues, a negedge monitor pops and compares every write the DUT presents.
`ifndef INT32
`define INT32 32
`endif
`ifndef INT8
`define INT8 8
`endif
`ifndef LENGTH
`define LENGTH 8
`endif

module tb_writeback_stage;
  localparam int VW = `LENGTH*`INT8;

  logic              clk = 1'b0;
  logic              reset;
  logic [4:0]        opcode, rD, conv_addr;
  logic [1:0]        wb;
  logic              ldr, conv_write;
  logic [`INT32-1:0] s_result, smem;
  logic [VW-1:0]     v_result, vmem, conv_result;
  logic              s_we, v_we, conv_stall, conv_overflow;
  logic [4:0]        s_waddr, v_waddr;
  logic [`INT32-1:0] s_wdata;
  logic [VW-1:0]     v_wdata;
  logic [2:0]        conv_count;
  logic [31:0]       retire_cnt;

  logic [5+`INT32-1:0] s_exp_q[$];
  logic [5+VW-1:0]     v_exp_q[$];
  logic [VW-1:0]       vrf9;
  int n_tests = 0;
  int n_fail  = 0;

  writeback_stage dut (
    .clk(clk), .reset(reset), .opcode(opcode), .rD(rD), .wb(wb), .ldr(ldr),
    .s_result(s_result), .v_result(v_result), .smem(smem), .vmem(vmem),
    .conv_result(conv_result), .conv_addr(conv_addr), .conv_write(conv_write),
    .s_we(s_we), .s_waddr(s_waddr), .s_wdata(s_wdata),
    .v_we(v_we), .v_waddr(v_waddr), .v_wdata(v_wdata),
    .conv_stall(conv_stall), .conv_overflow(conv_overflow),
    .conv_count(conv_count), .retire_cnt(retire_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb = 2'b00;
    ldr = 1'b0;
    conv_write = 1'b0;
  endtask

  task automatic exp_s(input logic [4:0] a, input logic [`INT32-1:0] d);
    s_exp_q.push_back({a, d});
  endtask

  task automatic exp_v(input logic [4:0] a, input logic [VW-1:0] d);
    v_exp_q.push_back({a, d});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " s_we"}, VW'(s_we), '0);
    check({tag, " s_waddr"}, VW'(s_waddr), '0);
    check({tag, " s_wdata"}, VW'(s_wdata), '0);
    check({tag, " v_we"}, VW'(v_we), '0);
    check({tag, " v_waddr"}, VW'(v_waddr), '0);
    check({tag, " v_wdata"}, v_wdata, '0);
    check({tag, " conv_stall"}, VW'(conv_stall), '0);
    check({tag, " conv_overflow"}, VW'(conv_overflow), '0);
    check({tag, " conv_count"}, VW'(conv_count), '0);
    check({tag, " retire_cnt"}, VW'(retire_cnt), '0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (s_we) begin
        n_tests++;
        if (s_exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL s_write_unexpected: got addr %0d data 0x%0h, none required", s_waddr, s_wdata);
        end else begin
          logic [5+`INT32-1:0] e;
          e = s_exp_q.pop_front();
          if ({s_waddr, s_wdata} !== e) begin
            n_fail++;
            $display("FAIL s_write: got addr %0d data 0x%0h, required addr %0d data 0x%0h",
                     s_waddr, s_wdata, e[5+`INT32-1:`INT32], e[`INT32-1:0]);
          end
        end
      end
      if (v_we) begin
        n_tests++;
        if (v_waddr == 5'd9) vrf9 = v_wdata;
        if (v_exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL v_write_unexpected: got addr %0d data 0x%0h, none required", v_waddr, v_wdata);
        end else begin
          logic [5+VW-1:0] e;
          e = v_exp_q.pop_front();
          if ({v_waddr, v_wdata} !== e) begin
            n_fail++;
            $display("FAIL v_write: got addr %0d data 0x%0h, required addr %0d data 0x%0h",
                     v_waddr, v_wdata, e[5+VW-1:VW], e[VW-1:0]);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    opcode = 5'd5; rD = '0; wb = '0; ldr = 1'b0; conv_addr = '0; conv_write = 1'b0;
    s_result = '0; smem = '0; v_result = '0; vmem = '0; conv_result = '0;
    vrf9 = '0;
    #2;
    check_all_zero("reset");
    tick();
    tick();
    reset = 1'b0;
    tick();

    // scalar writes: memory data then ALU data
    wb = 2'b01; ldr = 1'b1; rD = 5'd3; smem = 32'h12345678; s_result = 32'hDEADBEEF;
    exp_s(5'd3, 32'h12345678);
    tick();
    check("scalar_v_we_low", VW'(v_we), '0);
    wb = 2'b01; ldr = 1'b0; rD = 5'd4; s_result = 32'hCAFEF00D;
    exp_s(5'd4, 32'hCAFEF00D);
    tick();
    idle();

    // pipeline vector writes: ALU data then memory data
    wb = 2'b10; ldr = 1'b0; rD = 5'd5; v_result = 64'h0123_4567_89AB_CDEF; vmem = 64'h1111;
    exp_v(5'd5, 64'h0123_4567_89AB_CDEF);
    tick();
    wb = 2'b10; ldr = 1'b1; rD = 5'd6; vmem = 64'hFEDC_BA98_7654_3210;
    exp_v(5'd6, 64'hFEDC_BA98_7654_3210);
    tick();
    idle();

    // bypass into the vector port with an empty FIFO
    conv_write = 1'b1; conv_addr = 5'd7; conv_result = 64'hC0DE_0007;
    exp_v(5'd7, 64'hC0DE_0007);
    tick();
    check("bypass_count", VW'(conv_count), '0);
    idle();
    tick();

    // fill under continuous pipeline writes; fifth conv result is dropped
    for (int i = 0; i < 5; i++) begin
      wb = 2'b10; ldr = 1'b0; rD = 5'(10 + i); v_result = VW'(64'h1000 + i);
      conv_write = 1'b1; conv_addr = 5'(20 + i); conv_result = VW'(64'hC000 + i);
      exp_v(5'(10 + i), VW'(64'h1000 + i));
      tick();
      check("fill_count", VW'(conv_count), VW'((i + 1 > 4) ? 4 : i + 1));
      check("fill_stall", VW'(conv_stall), VW'(i + 1 >= 3));
      check("fill_overflow", VW'(conv_overflow), VW'(i == 4));
    end
    idle();
    for (int j = 0; j < 4; j++) exp_v(5'(20 + j), VW'(64'hC000 + j));
    for (int j = 0; j < 4; j++) begin
      tick();
      check("drain_count", VW'(conv_count), VW'(3 - j));
      check("drain_stall", VW'(conv_stall), VW'(3 - j >= 3));
    end
    check("overflow_sticky", VW'(conv_overflow), 'd1);
    tick();
    reset = 1'b1;
    #2;
    check("overflow_cleared", VW'(conv_overflow), '0);
    reset = 1'b0;
    tick();

    // queued conv to r9 is invalidated by a newer pipeline write to r9
    wb = 2'b10; rD = 5'd1; v_result = 64'hA1;
    conv_write = 1'b1; conv_addr = 5'd9; conv_result = 64'hC9;
    exp_v(5'd1, 64'hA1);
    tick();
    check("inval_enq_count", VW'(conv_count), 'd1);
    wb = 2'b10; rD = 5'd9; v_result = 64'hBEEF_0009; conv_write = 1'b0;
    exp_v(5'd9, 64'hBEEF_0009);
    tick();
    check("inval_hold_count", VW'(conv_count), 'd1);
    idle();
    tick();
    check("inval_pop_v_we", VW'(v_we), '0);
    check("inval_pop_count", VW'(conv_count), '0);
    tick();
    check("r9_pipeline_data", vrf9, 64'hBEEF_0009);

    // same-cycle conv to the pipeline target is younger and must survive
    wb = 2'b10; rD = 5'd12; v_result = 64'hB12;
    conv_write = 1'b1; conv_addr = 5'd12; conv_result = 64'hC12;
    exp_v(5'd12, 64'hB12);
    tick();
    check("young_conv_count", VW'(conv_count), 'd1);
    idle();
    exp_v(5'd12, 64'hC12);
    tick();
    check("young_conv_drained", VW'(conv_count), '0);
    tick();

    // reset mid-drain discards queued entries
    for (int i = 0; i < 3; i++) begin
      wb = 2'b10; rD = 5'(2 + i); v_result = VW'(64'hD00 + i);
      conv_write = 1'b1; conv_addr = 5'(15 + i); conv_result = VW'(64'hE00 + i);
      exp_v(5'(2 + i), VW'(64'hD00 + i));
      tick();
    end
    check("pre_reset_count", VW'(conv_count), 'd3);
    check("pre_reset_stall", VW'(conv_stall), 'd1);
    idle();
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_reset_v_we", VW'(v_we), '0);
    end

`ifdef WB_PERF_CNT_EN
    force dut.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_q;
    wb = 2'b01; opcode = 5'd5; rD = 5'd8; ldr = 1'b0; s_result = 32'h55;
    exp_s(5'd8, 32'h55);
    tick();
    idle();
    check("retire_wrap", VW'(retire_cnt), '0);
`else
    wb = 2'b01; opcode = 5'd5; rD = 5'd8; ldr = 1'b0; s_result = 32'h55;
    exp_s(5'd8, 32'h55);
    tick();
    idle();
    check("retire_const_zero", VW'(retire_cnt), '0);
`endif

    tick();
    tick();
    check("s_queue_empty", VW'(s_exp_q.size()), '0);
    check("v_queue_empty", VW'(v_exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
